// File: rtl/mic1_pkg.sv
// Shared widths, microinstruction layout and sequencer state encoding for the
// MIC-1 control-store sequencer.
package mic1_pkg;

    localparam int AW = 9;
    localparam int DW = 36;

    localparam int NA_MSB   = 35;
    localparam int NA_LSB   = 27;
    localparam int JMPC_BIT = 26;
    localparam int JAMN_BIT = 25;
    localparam int JAMZ_BIT = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC
    } seq_state_t;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [NA_MSB-NA_LSB:0] next_addr;
        logic                   jmpc;
        logic                   jamn;
        logic                   jamz;
        logic [JAMZ_BIT-1:0]    ctrl;
    } mir_t;

endpackage

// File: rtl/mic1_microsequencer_if.sv
// Loader, control-store and datapath signals of the sequencer; the master
// modport is the sequencer, the slave modport is its surroundings.
interface mic1_microsequencer_if;
    import mic1_pkg::*;

    logic          load_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          run;
    logic          cs_wen;
    logic [AW-1:0] cs_waddr;
    logic [DW-1:0] cs_wdata;
    logic          cs_ren;
    logic [AW-1:0] cs_raddr;
    logic [DW-1:0] cs_rdata;
    logic [DW-1:0] mir;
    logic          mir_valid;
    logic          dp_done;
    logic          alu_n;
    logic          alu_z;
    logic [7:0]    mbr;
    logic [AW-1:0] mpc;
    logic          loaded;
    logic          busy;

    modport master (
        input  load_start, ld_valid, ld_data, ld_last, run, cs_rdata,
               dp_done, alu_n, alu_z, mbr,
        output ld_ready, cs_wen, cs_waddr, cs_wdata, cs_ren, cs_raddr,
               mir, mir_valid, mpc, loaded, busy
    );

    modport slave (
        output load_start, ld_valid, ld_data, ld_last, run, cs_rdata,
               dp_done, alu_n, alu_z, mbr,
        input  ld_ready, cs_wen, cs_waddr, cs_wdata, cs_ren, cs_raddr,
               mir, mir_valid, mpc, loaded, busy
    );

endinterface

// File: rtl/mic1_next_addr.sv
// Combinational next-MPC former: NEXT_ADDRESS with JAMN/JAMZ OR-ed into the
// high bit and MBR OR-ed into the low byte when JMPC is set.
module mic1_next_addr
    import mic1_pkg::*;
(
    input  mir_t          mir,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic [7:0]    mbr,
    output logic [AW-1:0] next_mpc
);

    always_comb begin
        next_mpc      = mir.next_addr;
        next_mpc[8]   = mir.next_addr[8] | (mir.jamn & alu_n) | (mir.jamz & alu_z);
        next_mpc[7:0] = mir.next_addr[7:0] | (mir.jmpc ? mbr : 8'h00);
    end

endmodule

// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: boot-loads microcode into the control store, then
// runs the FETCH/WAIT/EXEC loop that feeds MIR to the datapath.
module mic1_microsequencer
    import mic1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mic1_microsequencer_if.master  bus
);

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [AW-1:0] mpc;
    logic [AW-1:0] wcount;
    mir_t          mir;
    logic          loaded;
    logic [AW-1:0] next_mpc;
    logic          xfer;
    logic          load_end;

    mic1_next_addr u_next_addr (
        .mir      (mir),
        .alu_n    (bus.alu_n),
        .alu_z    (bus.alu_z),
        .mbr      (bus.mbr),
        .next_mpc (next_mpc)
    );

    // The load finishes on ld_last or on the top word so the counter never wraps.
    assign xfer     = bus.ld_valid && (state == ST_LOAD);
    assign load_end = xfer && (bus.ld_last || (wcount == {AW{1'b1}}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mpc    <= '0;
            mir    <= '0;
            loaded <= 1'b0;
            wcount <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        wcount <= '0;
                        loaded <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_end) begin
                        loaded <= 1'b1;
                        mpc    <= '0;
                    end else if (xfer) begin
                        wcount <= wcount + 1'b1;
                    end
                end
                ST_WAIT: mir <= mir_t'(bus.cs_rdata);
                ST_EXEC: begin
                    if (bus.dp_done) begin
                        mpc <= next_mpc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_nx = ST_LOAD;
                end else if (bus.run && loaded) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_LOAD: begin
                if (load_end) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FETCH: state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_EXEC;
            ST_EXEC: begin
                if (bus.dp_done) begin
                    state_nx = bus.run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Write and read strobes come from disjoint states, so they never overlap.
    always_comb begin
        bus.ld_ready  = (state == ST_LOAD);
        bus.cs_wen    = xfer;
        bus.cs_waddr  = wcount;
        bus.cs_wdata  = bus.ld_data;
        bus.cs_ren    = (state == ST_FETCH);
        bus.cs_raddr  = mpc;
        bus.mir       = mir;
        bus.mir_valid = (state == ST_EXEC);
        bus.mpc       = mpc;
        bus.loaded    = loaded;
        bus.busy      = (state != ST_IDLE);
    end

endmodule
